mux6_stream_arbiter: RTL and testbench
======================================

// Module: mux6_stream_arbiter
// PURPOSE
//  Round-robin, packet-locked arbiter for a 6-to-1 32-bit stream mux in the 2x2 CGRA.
//  Six upstream valid/ready/last streams compete for one output; the block drives the mux select.
//  It also steers valid/ready between the winning input and the output.
//  Data never passes through this block; it sits beside the mux, one per PE input port.
// PARAMETERS
//  N_IN       6   number of requesters; fixed at 6 (select width 3)
//  MAX_BEATS  0   force release after this many beats in one grant; 0 = unlimited
//  CNT_W      8   width of beat counter; MAX_BEATS must be < 2**CNT_W
// PORTS
//  clk         in   1  single clock, rising edge
//  reset       in   1  asynchronous, active-high reset
//  en_mask     in   6  per-input enable; a disabled input is never newly granted
//  in_valid    in   6  per-input valid
//  in_last     in   6  per-input end-of-packet flag, qualified by in_valid
//  in_ready    out  6  per-input ready; only bit [sel] can be 1
//  out_ready   in   1  downstream ready
//  out_valid   out  1  = in_valid[sel] while BUSY, else 0
//  out_last    out  1  = in_last[sel] while BUSY, else 0
//  sel         out  3  registered mux select, range 0..5, never 6/7
//  busy        out  1  1 while a grant is held
// BEHAVIOUR
//  Reset values: sel=0, busy=0, state=IDLE, rr_ptr=5 (input 0 wins first), beat_cnt=0.
//  While IDLE: out_valid=0, in_ready=0.
//  IDLE:
//   - eligible = in_valid & en_mask.
//   - If eligible != 0, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo 6.
//   - Register sel=winner, rr_ptr=winner, beat_cnt=0, go to BUSY.
//   - Latency: 1 cycle from request to out_valid.
//  BUSY:
//   - in_ready[sel] = out_ready; out_valid/out_last mirror input sel; other in_ready bits = 0.
//   - Beat = out_valid & out_ready. Each beat increments beat_cnt (saturating).
//   - Release (go to IDLE next cycle) on a beat with out_last=1.
//   - Also release on a beat where MAX_BEATS != 0 and beat_cnt == MAX_BEATS-1.
//  Grant lock: sel is stable for the whole of BUSY.
//   - If in_valid[sel] drops mid-packet, the grant is held and out_valid=0.
//   - Clearing en_mask[sel] mid-packet does not revoke the grant; it only takes effect at the next arbitration.
//  Release timing: one IDLE bubble cycle after every release; no back-to-back re-grant in the same cycle.
//  Fairness: after a release the just-served input has lowest priority. Worst-case wait is 5 grants.
//  Simultaneous events: release and a new request in the same cycle -> the request is arbitrated in the following IDLE cycle.
//  Reset mid-packet: returns to IDLE immediately (async). The packet in flight is truncated; upstream must re-send.
//  No combinational path from in_valid to sel. out_valid depends combinationally on in_valid[sel].
// STRUCTURE
//  Shared header stream2x2_arb_defs.vh:
//   - ST_IDLE=1'b0, ST_BUSY=1'b1
//   - N_IN=6, SEL_W=3
//  Sub-module rr_pick6:
//   - combinational rotate-priority picker
//   - inputs: req[5:0], ptr[2:0]; outputs: any, idx[2:0]
//   - unit-testable standalone
//  Top level: state register, sel/rr_ptr/beat_cnt registers, output steering.
// TESTING
//  1. Reset, then in_valid=6'b000001 with 3 beats (last on beat 3), out_ready=1.
//     -> sel=0 one cycle after request; 3 beats out; busy drops after the last beat.
//  2. All 6 requesting continuously with 1-beat packets.
//     -> grant order 0,1,2,3,4,5,0, with one idle cycle between grants.
//  3. Input 2 granted, 4-beat packet; out_ready toggles 1,0,1,0.
//     -> in_ready[2] tracks out_ready; sel stays 2; no beat lost or duplicated.
//  4. en_mask=6'b111011 with inputs 2 and 3 valid.
//     -> 3 granted, 2 never; clearing en_mask[3] mid-packet does not abort it.
//  5. MAX_BEATS=4, input 1 streams 10 beats with no last.
//     -> release after beat 4; a waiting input 4 is granted next; input 1 resumes later.
//  6. Assert reset on beat 2 of a 5-beat packet.
//     -> same edge: busy=0, sel=0, in_ready=0; next grant favours input 0.

Source files
------------

// File: rtl/mux6_stream_arbiter_pkg.sv
// Shared definitions for the 6-input round-robin stream arbiter.
package mux6_stream_arbiter_pkg;

    localparam int N_IN  = 6;
    localparam int SEL_W = 3;

    // Input 5 is treated as the last winner after reset, so input 0 wins first.
    localparam logic [SEL_W-1:0] PTR_RESET = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mux6_stream_arbiter_pick.sv
// Rotating-priority picker: the first set request after ptr, modulo 6, wins.
module rr_pick6
    import mux6_stream_arbiter_pkg::*;
(
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W:0]   sum;
    logic [SEL_W-1:0] pos;

    // Walk the six positions after ptr in priority order; the first hit is kept.
    always_comb begin
        any = 1'b0;
        idx = '0;
        sum = '0;
        pos = '0;
        for (int k = 1; k <= N_IN; k++) begin
            sum = {1'b0, ptr} + (SEL_W + 1)'(k);
            if (sum >= (SEL_W + 1)'(N_IN)) begin
                sum = sum - (SEL_W + 1)'(N_IN);
            end
            pos = sum[SEL_W-1:0];
            if (!any && req[pos]) begin
                any = 1'b1;
                idx = pos;
            end
        end
    end

endmodule

// File: rtl/mux6_stream_arbiter.sv
// Packet-locked round-robin arbiter driving the select of a 6:1 stream mux.
//
// Handshake: a beat transfers on a cycle where valid and ready are both high
// at the rising clock edge. valid never waits on ready; in_ready[sel] is a
// direct combinational copy of out_ready while a grant is held, and all other
// in_ready bits are 0. MAX_BEATS must be below 2**CNT_W.
module mux6_stream_arbiter
    import mux6_stream_arbiter_pkg::*;
#(
    parameter int MAX_BEATS = 0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IN-1:0]  en_mask,
    input  logic [N_IN-1:0]  in_valid,
    input  logic [N_IN-1:0]  in_last,
    output logic [N_IN-1:0]  in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             out_last,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output arb_state_e       state
);

    arb_state_e       state_d;
    logic [SEL_W-1:0] sel_d;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_d;
    logic [N_IN-1:0]  eligible;
    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             beat;
    logic             cap_hit;

    assign eligible = in_valid & en_mask;
    assign busy     = (state == ST_BUSY);

    rr_pick6 u_pick (
        .req (eligible),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // State register; reset drops any packet in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Grant registers: select, round-robin pointer and beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel      <= '0;
            rr_ptr   <= PTR_RESET;
            beat_cnt <= '0;
        end else begin
            sel      <= sel_d;
            rr_ptr   <= rr_ptr_d;
            beat_cnt <= beat_cnt_d;
        end
    end

    // Arbitrate when idle, steer the handshake and detect release when busy.
    always_comb begin
        state_d    = state;
        sel_d      = sel;
        rr_ptr_d   = rr_ptr;
        beat_cnt_d = beat_cnt;
        in_ready   = '0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        beat       = 1'b0;
        cap_hit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d    = ST_BUSY;
                    sel_d      = pick_idx;
                    rr_ptr_d   = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                out_valid     = in_valid[sel];
                out_last      = in_last[sel];
                in_ready[sel] = out_ready;
                beat          = out_valid & out_ready;
                cap_hit       = (MAX_BEATS != 0) && (beat_cnt == CNT_W'(MAX_BEATS - 1));
                if (beat) begin
                    if (beat_cnt != '1) begin
                        beat_cnt_d = beat_cnt + 1'b1;
                    end
                    // Release always costs one idle cycle before the next grant.
                    if (out_last || cap_hit) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux6_stream_arbiter.sv
// Bench for mux6_stream_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural reference model.
module tb_mux6_stream_arbiter;
    import mux6_stream_arbiter_pkg::*;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] en_mask = 6'h3f;
    logic [5:0] in_valid = '0;
    logic [5:0] in_last = '0;
    logic [5:0] in_ready;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic       out_last;
    logic [2:0] sel;
    logic       busy;
    arb_state_e state;

    int errors = 0;
    int checks = 0;

    // reference model of the arbiter
    bit m_busy;
    int m_sel, m_ptr, m_cnt;

    // upstream sources: beats left, valid duty in percent, packet without last
    int rem[6];
    int duty;
    bit no_last[6];
    int refill_len;

    // scoreboard of grant order and observed beats
    logic [2:0] exp_q[$];
    logic [2:0] got_q[$];
    bit prev_busy;
    int beats_seen;
    int sel2_grants;

    mux6_stream_arbiter #(.MAX_BEATS(MAXB), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en_mask(en_mask), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_ready(out_ready),
        .out_valid(out_valid), .out_last(out_last), .sel(sel), .busy(busy),
        .state(state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_sel = 0; m_ptr = 5; m_cnt = 0;
        prev_busy = 1'b0;
        for (int i = 0; i < 6; i++) begin rem[i] = 0; no_last[i] = 1'b0; end
        refill_len = 0;
    endtask

    // Asynchronous reset applied at the current time; outputs checked right after.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_sel", sel, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        model_reset();
        in_valid = '0; in_last = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // One clock: drive sources, check outputs mid-cycle, advance model and sources.
    task automatic cycle();
        logic [5:0] v, l, elig, exp_rdy;
        logic exp_ov, exp_ol;
        int p;
        for (int i = 0; i < 6; i++) begin
            v[i] = (rem[i] > 0) && ($urandom_range(99) < duty);
            l[i] = (rem[i] == 1) && !no_last[i];
        end
        in_valid = v; in_last = l;
        @(negedge clk);
        exp_rdy = '0;
        if (m_busy && out_ready) exp_rdy[m_sel] = 1'b1;
        exp_ov = m_busy && v[m_sel];
        exp_ol = m_busy && l[m_sel];
        check("busy", busy, m_busy);
        check("state", 32'(state), m_busy);
        check("sel", sel, m_sel);
        check("in_ready", in_ready, exp_rdy);
        check("out_valid", out_valid, exp_ov);
        check("out_last", out_last, exp_ol);
        if (busy && !prev_busy) got_q.push_back(sel);
        if (busy && sel == 3'd2) sel2_grants++;
        prev_busy = busy;
        if (out_valid && out_ready) beats_seen++;
        for (int i = 0; i < 6; i++) begin
            if (exp_rdy[i] && v[i]) begin
                rem[i]--;
                if (rem[i] == 0 && refill_len != 0) rem[i] = refill_len;
            end
        end
        if (!m_busy) begin
            elig = v & en_mask;
            for (int k = 1; k <= 6; k++) begin
                p = (m_ptr + k) % 6;
                if (!m_busy && elig[p]) begin
                    m_busy = 1'b1; m_sel = p; m_ptr = p; m_cnt = 0;
                end
            end
        end else if (exp_ov && out_ready) begin
            if (exp_ol || (MAXB != 0 && m_cnt == MAXB - 1)) m_busy = 1'b0;
            if (m_cnt < 255) m_cnt++;
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        model_reset();
        duty = 100;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // single 3-beat packet on input 0
        out_ready = 1'b1; beats_seen = 0; got_q.delete();
        rem[0] = 3;
        run(8);
        check("t1_beats", beats_seen, 3);
        check("t1_grants", got_q.size(), 1);

        // all six requesting with 1-beat packets: strict rotation
        do_reset();
        got_q.delete();
        for (int i = 0; i < 6; i++) rem[i] = 1;
        refill_len = 1;
        run(15);
        exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        check("t2_ngrants", got_q.size() >= 7, 1);
        for (int j = 0; j < 7 && j < got_q.size(); j++) check("t2_order", got_q[j], exp_q[j]);
        refill_len = 0;

        // input 2, 4-beat packet under toggling out_ready
        do_reset();
        beats_seen = 0;
        rem[2] = 4;
        for (int i = 0; i < 12; i++) begin
            out_ready = i[0];
            cycle();
        end
        check("t3_beats", beats_seen, 4);
        check("t3_rem", rem[2], 0);

        // masked input never granted; clearing the mask mid-packet does not abort
        do_reset();
        out_ready = 1'b1; en_mask = 6'b111011; beats_seen = 0; sel2_grants = 0;
        rem[2] = 3; rem[3] = 4;
        run(2);
        en_mask = 6'b110011;
        run(8);
        check("t4_beats", beats_seen, 4);
        check("t4_sel2", sel2_grants, 0);
        en_mask = 6'h3f;
        run(6);

        // forced release after MAXB beats; waiting input 4 goes next
        do_reset();
        got_q.delete();
        rem[1] = 10; no_last[1] = 1'b1; rem[4] = 2;
        run(20);
        exp_q = '{3'd1, 3'd4, 3'd1};
        check("t5_ngrants", got_q.size() >= 3, 1);
        for (int j = 0; j < 3 && j < got_q.size(); j++) check("t5_order", got_q[j], exp_q[j]);

        // reset during beat 2 of a 5-beat packet; input 0 wins afterwards
        do_reset();
        rem[3] = 5;
        run(2);
        check("t6_mid", rem[3], 4);
        do_reset();
        got_q.delete();
        rem[0] = 2; rem[3] = 5;
        run(4);
        check("t6_first", got_q.size() > 0 ? got_q[0] : 3'd7, 0);

        // random traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            duty = $urandom_range(40, 100);
            out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0) en_mask = 6'($urandom_range(63));
            for (int i = 0; i < 6; i++) begin
                if (rem[i] == 0 && $urandom_range(3) == 0) begin
                    rem[i] = $urandom_range(1, 6);
                    no_last[i] = ($urandom_range(7) == 0);
                end
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
